// File: rtl/ahb_lite_decoder.sv
// AHB-Lite address decoder and slave-response multiplexer with a built-in
// default slave (two-cycle ERROR on unmapped active transfers) and error counter.
module ahb_lite_decoder #(
  parameter int unsigned          NSLV = 4,
  parameter logic [NSLV*4-1:0]    BASE = (NSLV*4)'(32'h0000_8420)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  output logic [NSLV-1:0]        HSEL,
  input  logic [NSLV*32-1:0]     S_HRDATA,
  input  logic [NSLV-1:0]        S_HREADYOUT,
  input  logic [NSLV-1:0]        S_HRESP,
  output logic                   HREADY,
  output logic                   HRESP,
  output logic [31:0]            HRDATA,
  output logic [7:0]             ERRCNT
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] DS_OK   = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  logic [NSLV-1:0]  hsel_dec_c;
  logic             hit_c;
  logic [NSLV-1:0]  dsel_q;
  logic             dsel_def_q;
  logic [1:0]       ds_state_q;
  logic [1:0]       ds_next_c;
  logic             ds_ready_c;
  logic             ds_resp_c;
  logic             err_start_c;
  logic [CNT_W-1:0] errcnt_q;
  logic             unused_ok;

  assign unused_ok = ^{HADDR[27:0], HTRANS[0]};

  // Address decode; lowest index wins on overlapping region codes.
  always_comb begin
    hsel_dec_c = '0;
    hit_c      = 1'b0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (!hit_c && (HADDR[31:28] == BASE[4*i +: 4])) begin
        hsel_dec_c[i] = 1'b1;
        hit_c         = 1'b1;
      end
    end
  end

  assign HSEL = hsel_dec_c;

  // Data-phase select advances only when the bus is ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q     <= '0;
      dsel_def_q <= 1'b1;
    end else if (HREADY) begin
      dsel_q     <= hsel_dec_c;
      dsel_def_q <= !hit_c;
    end
  end

  assign err_start_c = HREADY && !hit_c && HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ds_state_q <= DS_OK;
    else          ds_state_q <= ds_next_c;
  end

  // Default-slave next state and response.
  always_comb begin
    ds_next_c  = DS_OK;
    ds_ready_c = 1'b1;
    ds_resp_c  = 1'b0;
    case (ds_state_q)
      DS_ERR1: begin
        ds_ready_c = 1'b0;
        ds_resp_c  = 1'b1;
        ds_next_c  = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp_c  = 1'b1;
        ds_next_c  = err_start_c ? DS_ERR1 : DS_OK;
      end
      default: begin
        ds_next_c  = err_start_c ? DS_ERR1 : DS_OK;
      end
    endcase
  end

  // Saturating count of ERR1 entries.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      errcnt_q <= '0;
    end else if ((ds_next_c == DS_ERR1) && (errcnt_q != {CNT_W{1'b1}})) begin
      errcnt_q <= errcnt_q + CNT_W'(1);
    end
  end

  assign ERRCNT = errcnt_q;

  // Response mux; dsel is one-hot or default, so OR-reduction is exact.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b0;
    HRESP  = 1'b0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (dsel_q[i]) begin
        HRDATA = HRDATA | S_HRDATA[32*i +: 32];
        HREADY = HREADY | S_HREADYOUT[i];
        HRESP  = HRESP  | S_HRESP[i];
      end
    end
    if (dsel_def_q) begin
      HREADY = ds_ready_c;
      HRESP  = ds_resp_c;
    end
  end

endmodule

// File: tb/tb_ahb_lite_decoder.sv
// Directed self-checking bench for ahb_lite_decoder: reset, routing, wait
// states, default-slave ERROR sequencing, counter saturation, reset mid-error.
module tb_ahb_lite_decoder;

  logic         HCLK;
  logic         HRESETn;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [3:0]   HSEL;
  logic [127:0] S_HRDATA;
  logic [3:0]   S_HREADYOUT;
  logic [3:0]   S_HRESP;
  logic         HREADY;
  logic         HRESP;
  logic [31:0]  HRDATA;
  logic [7:0]   ERRCNT;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] D0 = 32'hA0A0_A0A0;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h2222_2222;
  localparam logic [31:0] D3 = 32'h3333_3333;

  ahb_lite_decoder #(.NSLV(4), .BASE(16'h8420)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .S_HRDATA    (S_HRDATA),
    .S_HREADYOUT (S_HREADYOUT),
    .S_HRESP     (S_HRESP),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .ERRCNT      (ERRCNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one address-phase cycle just after the edge, then wait to the sample point.
  task automatic cyc(input logic [31:0] addr, input logic [1:0] trans);
    @(posedge HCLK);
    #1;
    HADDR  = addr;
    HTRANS = trans;
    @(negedge HCLK);
  endtask

  initial begin
    HRESETn     = 1'b0;
    HADDR       = 32'hF000_0000;
    HTRANS      = 2'b10;
    S_HRDATA    = {4{32'hDEAD_BEEF}};
    S_HREADYOUT = 4'b0000;
    S_HRESP     = 4'b1111;

    // Reset with arbitrary slave inputs
    repeat (3) @(negedge HCLK);
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp",  32'(HRESP),  32'd0);
    chk("rst_hrdata", HRDATA,      32'd0);
    chk("rst_errcnt", 32'(ERRCNT), 32'd0);

    @(posedge HCLK);
    #1;
    HRESETn     = 1'b1;
    HADDR       = 32'h0000_0000;
    HTRANS      = 2'b00;
    S_HRDATA    = {D3, D2, D1, D0};
    S_HREADYOUT = 4'b1111;
    S_HRESP     = 4'b0000;
    @(negedge HCLK);
    chk("post_rst_hready", 32'(HREADY), 32'd1);
    chk("post_rst_hresp",  32'(HRESP),  32'd0);
    chk("post_rst_hrdata", HRDATA,      32'd0);
    chk("post_rst_errcnt", 32'(ERRCNT), 32'd0);

    // Routing
    cyc(32'h2000_0010, 2'b10);
    chk("route_hsel1", 32'(HSEL), 32'h2);
    cyc(32'h4000_0000, 2'b10);
    chk("route_hsel2",   32'(HSEL), 32'h4);
    chk("route_hrdata1", HRDATA,    D1);
    cyc(32'h8000_0000, 2'b10);
    chk("route_hsel3",   32'(HSEL), 32'h8);
    chk("route_hrdata2", HRDATA,    D2);

    // Slave3 inserts two wait states while next address targets slave0
    cyc(32'h0000_0004, 2'b10);
    S_HREADYOUT = 4'b0111;
    #1;
    chk("wait1_hready", 32'(HREADY), 32'd0);
    chk("wait1_hrdata", HRDATA,      D3);
    chk("wait1_hsel",   32'(HSEL),   32'h1);
    cyc(32'h0000_0004, 2'b10);
    chk("wait2_hready", 32'(HREADY), 32'd0);
    chk("wait2_hrdata", HRDATA,      D3);
    cyc(32'h0000_0004, 2'b10);
    S_HREADYOUT = 4'b1111;
    #1;
    chk("wait_end_hready", 32'(HREADY), 32'd1);
    chk("wait_end_hrdata", HRDATA,      D3);

    // Unmapped active transfer
    cyc(32'hF000_0000, 2'b10);
    chk("unm_hsel",   32'(HSEL), 32'h0);
    chk("unm_slv0",   HRDATA,    D0);
    chk("unm_hready", 32'(HREADY), 32'd1);
    cyc(32'h0000_0000, 2'b00);
    chk("err1_hready", 32'(HREADY), 32'd0);
    chk("err1_hresp",  32'(HRESP),  32'd1);
    chk("err1_hrdata", HRDATA,      32'd0);
    chk("err1_errcnt", 32'(ERRCNT), 32'd1);
    cyc(32'h0000_0000, 2'b00);
    chk("err2_hready", 32'(HREADY), 32'd1);
    chk("err2_hresp",  32'(HRESP),  32'd1);

    // Unmapped idle transfer
    cyc(32'hF000_0000, 2'b00);
    chk("ok_hready", 32'(HREADY), 32'd1);
    chk("ok_hresp",  32'(HRESP),  32'd0);
    cyc(32'h0000_0000, 2'b00);
    chk("idle_unm_hready", 32'(HREADY), 32'd1);
    chk("idle_unm_hresp",  32'(HRESP),  32'd0);
    chk("idle_unm_hrdata", HRDATA,      32'd0);
    chk("idle_unm_errcnt", 32'(ERRCNT), 32'd1);

    // 260 back-to-back unmapped NONSEQ transfers
    cyc(32'hC000_0000, 2'b10);
    chk("sat_first_hready", 32'(HREADY), 32'd1);
    for (int t = 0; t < 260; t++) begin
      cyc(32'hC000_0000, 2'b10);
      chk("sat_err1_hready", 32'(HREADY), 32'd0);
      chk("sat_err1_hresp",  32'(HRESP),  32'd1);
      chk("sat_err1_errcnt", 32'(ERRCNT), (t + 2 > 255) ? 32'd255 : 32'(t + 2));
      if (t == 259) cyc(32'h0000_0000, 2'b00);
      else          cyc(32'hC000_0000, 2'b10);
      chk("sat_err2_hready", 32'(HREADY), 32'd1);
      chk("sat_err2_hresp",  32'(HRESP),  32'd1);
    end
    cyc(32'h0000_0000, 2'b00);
    chk("sat_end_hready", 32'(HREADY), 32'd1);
    chk("sat_end_hresp",  32'(HRESP),  32'd0);
    chk("sat_end_errcnt", 32'(ERRCNT), 32'hFF);

    // Reset asserted in the middle of an ERROR response
    cyc(32'hF000_0000, 2'b10);
    cyc(32'h0000_0000, 2'b00);
    chk("mid_err1_hready", 32'(HREADY), 32'd0);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_hready", 32'(HREADY), 32'd1);
    chk("mid_rst_hresp",  32'(HRESP),  32'd0);
    chk("mid_rst_errcnt", 32'(ERRCNT), 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    cyc(32'h2000_0000, 2'b10);
    chk("after_rst_hready", 32'(HREADY), 32'd1);
    chk("after_rst_hresp",  32'(HRESP),  32'd0);
    cyc(32'h0000_0000, 2'b00);
    chk("after_rst_hrdata", HRDATA,      D1);
    chk("after_rst_errcnt", 32'(ERRCNT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_decoder.md
# ahb_lite_decoder

AHB-Lite address decoder and slave-response multiplexer for a single-master SoC bus. It sits directly upstream of the bus slaves, including the on-chip AHB memory. It drives each slave's HSEL from the address-phase HADDR and routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master during the data phase. It contains a built-in default slave that returns a two-cycle ERROR response for active transfers to unmapped addresses, plus a saturating error counter for diagnostics.

## Interface
- NSLV, 4, number of mapped slaves (1..8)
- BASE, 32'h0000_8420, packed NSLV×4-bit region codes; slave i owns HADDR[31:28] == BASE[4i+3:4i] (default: s0=0x0, s1=0x2, s2=0x4, s3=0x8)
- HCLK  in  1  bus clock, all state on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HADDR  in  32  master address (address phase)
- HTRANS  in  2  master transfer type; bit 1 set = NONSEQ/SEQ (active)
- HSEL  out  NSLV  one-hot slave select, combinational from HADDR
- S_HRDATA  in  NSLV×32  packed slave read data, slave i at [32i+31:32i]
- S_HREADYOUT  in  NSLV  per-slave HREADYOUT
- S_HRESP  in  NSLV  per-slave HRESP
- HREADY  out  1  muxed ready, driven to master and to every slave's HREADY
- HRESP  out  1  muxed response to master (0 OKAY, 1 ERROR)
- HRDATA  out  32  muxed read data to master
- ERRCNT  out  8  saturating count of default-slave ERROR responses

## Operation
- Decode: HSEL[i] = (HADDR[31:28] == BASE code i). On overlapping codes, the lowest index wins; HSEL is never multi-hot. No match: HSEL = 0 and the default slave is selected. HSEL does not depend on HTRANS.
- Data-phase select register dsel (one-hot NSLV bits + default flag): loads the address-phase decode on every rising edge where HREADY = 1; holds otherwise.
- Mux, combinational from dsel:
  - Slave i selected: HREADY = S_HREADYOUT[i], HRESP = S_HRESP[i], HRDATA = S_HRDATA slice i.
  - Default selected: HREADY/HRESP come from the default-slave FSM, HRDATA = 32'h0.
- Default-slave FSM, states DS_OK, DS_ERR1, DS_ERR2:
  - DS_OK outputs HREADY=1, HRESP=0. Transitions to DS_ERR1 on an edge with HREADY=1, no region match, and HTRANS[1]=1. Otherwise stays in DS_OK.
  - DS_ERR1 outputs HREADY=0, HRESP=1. Always transitions to DS_ERR2.
  - DS_ERR2 outputs HREADY=1, HRESP=1. Then re-evaluates exactly as DS_OK does: a back-to-back active unmapped transfer goes to DS_ERR1, anything else goes to DS_OK.
- IDLE/BUSY (HTRANS[1]=0) to an unmapped address gets a zero-wait OKAY.
- IDLE/BUSY to a mapped slave is routed to that slave; the slave is responsible for OKAY.
- ERRCNT increments by 1 on each DS_ERR1 entry. It saturates at 8'hFF and never wraps.
- Master-side abort after an ERROR is not special-cased. The decoder simply follows HTRANS/HADDR presented while HREADY=1.

## Timing
- Reset (asynchronous, HRESETn low): dsel = default, FSM = DS_OK, ERRCNT = 0. Outputs are therefore HREADY=1, HRESP=0, HRDATA=0. HSEL stays combinational from HADDR.
- Reset asserted mid-ERROR or mid-wait-state: the FSM returns to DS_OK immediately and the next transfer is decoded fresh.
- Decode latency 0: HSEL is valid in the same cycle as HADDR.
- Response latency: data-phase outputs follow dsel, which is registered one edge after the address phase. While dsel is held, mux outputs follow slave inputs combinationally.
- Slave wait states: while S_HREADYOUT=0, dsel holds and HSEL for the next address is still driven. Slaves must gate on HREADY.
- Unmapped active transfer costs exactly 2 data-phase cycles: ERR1 then ERR2, with HREADY low for 1 cycle.
- There is no combinational path from S_* inputs to HSEL.

## Test plan
- Reset: hold HRESETn=0, toggle HCLK, drive slave inputs arbitrarily. Release reset. Required: HREADY=1, HRESP=0, HRDATA=0, ERRCNT=0 both during reset and on the first cycle after release.
- Routing: NONSEQ read to 0x2000_0010, then 0x4000_0000, with S_HRDATA slice1=0x1111_1111 and slice2=0x2222_2222.
  - HSEL=4'b0010 then 4'b0100 during the address phases.
  - HRDATA=0x1111_1111 on the cycle after the first address phase, then 0x2222_2222 on the next.
- Wait state: slave3 drives S_HREADYOUT=0 for 2 cycles on an access to 0x8000_0000, while the master presents the next address 0x0000_0004.
  - HREADY=0 for 2 cycles and dsel holds slave3.
  - dsel switches to slave0 only after HREADY=1.
- Unmapped active transfer: NONSEQ to 0xF000_0000. Required: HSEL=0, then HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then back to OKAY. ERRCNT=1.
- Unmapped idle transfer: IDLE to 0xF000_0000. Required: HREADY=1, HRESP=0 on the next cycle, and ERRCNT unchanged.
- Saturation: issue 260 back-to-back NONSEQ transfers to 0xC000_0000. Required: every transfer gets an ERR1/ERR2 pair, and ERRCNT=8'hFF at the end without wrapping.
